// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-port APB request arbiter.
package apb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam int unsigned TIMEOUT_DEFAULT = 16;
   // Wait counter width covers the full legal TIMEOUT range (2..255).
   localparam int unsigned WAIT_W = 8;

endpackage

// File: rtl/apb_req_arbiter_rr_arb2.sv
// Two-way round-robin grant; the requester not granted last wins a tie.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   // Index of the requester granted most recently; reset value favours requester 0.
   logic last;

   always_comb begin
      grant = '0;
      if (req[0] && req[1]) begin
         if (last) grant = 2'b01;
         else      grant = 2'b10;
      end else begin
         grant = req;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= 1'b1;
      end else if (advance && (grant != '0)) begin
         last <= grant[1];
      end
   end

endmodule

// File: rtl/apb_req_arbiter.sv
// Two-requester APB master: round-robin accept in IDLE, SETUP/ACCESS phases, PREADY timeout.
module apb_req_arbiter
   import apb_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic              PCLK,
   input  logic              PRESETn,

   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic              req0_write,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   output logic              rsp0_err,

   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic              req1_write,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              rsp1_err,

   output logic [ADDR_W-1:0] PADDR,
   output logic              PWRITE,
   output logic [DATA_W-1:0] PWDATA,
   output logic              PSEL,
   output logic              PENABLE,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY
);

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   apb_state_e        state;
   apb_state_e        state_nxt;
   logic [1:0]        grant;
   logic              accept;
   logic              owner;
   logic              done_ok;
   logic              done_err;
   logic [WAIT_W-1:0] wait_cnt;

   rr_arb2 u_rr (
      .clk     (PCLK),
      .rst_n   (PRESETn),
      .req     ({req1_valid, req0_valid}),
      .advance (accept),
      .grant   (grant)
   );

   // Accept is gated with PRESETn so no ready can leak out while reset is held.
   always_comb begin
      accept   = (state == IDLE) && (grant != '0) && PRESETn;
      done_ok  = (state == ACCESS) && PREADY;
      done_err = (state == ACCESS) && !PREADY && (wait_cnt == WAIT_LAST);
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (done_ok || done_err) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      PSEL       = (state == SETUP) || (state == ACCESS);
      PENABLE    = (state == ACCESS);
      req0_ready = accept && grant[0];
      req1_ready = accept && grant[1];
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         PADDR  <= '0;
         PWRITE <= 1'b0;
         PWDATA <= '0;
         owner  <= 1'b0;
      end else if (accept) begin
         owner <= grant[1];
         if (grant[1]) begin
            PADDR  <= req1_addr;
            PWRITE <= req1_write;
            PWDATA <= req1_wdata;
         end else begin
            PADDR  <= req0_addr;
            PWRITE <= req0_write;
            PWDATA <= req0_wdata;
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         wait_cnt <= '0;
      end else if (state == SETUP) begin
         wait_cnt <= '0;
      end else if ((state == ACCESS) && !PREADY) begin
         wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end

   // Response outputs are single-cycle pulses: everything returns to 0 unless a completion lands.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         rsp0_valid <= 1'b0;
         rsp0_rdata <= '0;
         rsp0_err   <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp1_rdata <= '0;
         rsp1_err   <= 1'b0;
      end else begin
         rsp0_valid <= 1'b0;
         rsp0_rdata <= '0;
         rsp0_err   <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp1_rdata <= '0;
         rsp1_err   <= 1'b0;
         if (done_ok || done_err) begin
            if (owner) begin
               rsp1_valid <= 1'b1;
               rsp1_err   <= done_err;
               if (done_ok && !PWRITE) rsp1_rdata <= PRDATA;
            end else begin
               rsp0_valid <= 1'b1;
               rsp0_err   <= done_err;
               if (done_ok && !PWRITE) rsp0_rdata <= PRDATA;
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed self-checking bench for apb_req_arbiter (TIMEOUT overridden to 4).
module tb_apb_req_arbiter;

   logic        PCLK;
   logic        PRESETn;
   logic        req0_valid, req0_ready, req0_write;
   logic [31:0] req0_addr, req0_wdata;
   logic        rsp0_valid, rsp0_err;
   logic [31:0] rsp0_rdata;
   logic        req1_valid, req1_ready, req1_write;
   logic [31:0] req1_addr, req1_wdata;
   logic        rsp1_valid, rsp1_err;
   logic [31:0] rsp1_rdata;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic        PWRITE, PSEL, PENABLE, PREADY;

   int n_checks = 0;
   int n_fail   = 0;

   apb_req_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .PCLK       (PCLK),
      .PRESETn    (PRESETn),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_addr  (req0_addr),
      .req0_write (req0_write),
      .req0_wdata (req0_wdata),
      .rsp0_valid (rsp0_valid),
      .rsp0_rdata (rsp0_rdata),
      .rsp0_err   (rsp0_err),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_addr  (req1_addr),
      .req1_write (req1_write),
      .req1_wdata (req1_wdata),
      .rsp1_valid (rsp1_valid),
      .rsp1_rdata (rsp1_rdata),
      .rsp1_err   (rsp1_err),
      .PADDR      (PADDR),
      .PWRITE     (PWRITE),
      .PWDATA     (PWDATA),
      .PSEL       (PSEL),
      .PENABLE    (PENABLE),
      .PRDATA     (PRDATA),
      .PREADY     (PREADY)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic step();
      @(negedge PCLK);
      #1;
   endtask

   task automatic test_reset();
      PRESETn = 1'b0;
      req0_valid = 1'b1; req0_addr = 32'h40; req0_write = 1'b1; req0_wdata = 32'h1;
      req1_valid = 1'b0; req1_addr = 32'h0;  req1_write = 1'b0; req1_wdata = 32'h0;
      PREADY = 1'b1; PRDATA = 32'h0;
      repeat (2) @(negedge PCLK);
      #1;
      n_checks++;
      if ({PSEL, PENABLE, PWRITE, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 000000000",
                  {PSEL, PENABLE, PWRITE, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err});
      end
      n_checks++;
      if ((PADDR | PWDATA | rsp0_rdata | rsp1_rdata) !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h/%h/%h/%h want all 0", PADDR, PWDATA, rsp0_rdata, rsp1_rdata);
      end
      req0_valid = 1'b0;
      @(negedge PCLK);
      PRESETn = 1'b1;
   endtask

   task automatic test_round_robin();
      step();
      req0_valid = 1'b1; req0_addr = 32'h00; req0_write = 1'b0;
      req1_valid = 1'b1; req1_addr = 32'h10; req1_write = 1'b0;
      PREADY = 1'b1; PRDATA = 32'hCAFE_0000;
      #1;
      n_checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         n_fail++; $display("FAIL rr_first_grant: got r0/r1=%b want 10", {req0_ready, req1_ready});
      end
      step();
      req0_valid = 1'b0;
      n_checks++;
      if ({PSEL, PENABLE, req0_ready, req1_ready} !== 4'b1000 || PADDR !== 32'h00) begin
         n_fail++; $display("FAIL rr_setup0: got sel/en/r0/r1=%b addr=%h want 1000 addr=0",
                            {PSEL, PENABLE, req0_ready, req1_ready}, PADDR);
      end
      step();
      step();
      n_checks++;
      if ({rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 4'b1001 || rsp0_rdata !== 32'hCAFE_0000) begin
         n_fail++; $display("FAIL rr_rsp0: got v0/v1/r0/r1=%b rdata=%h want 1001 cafe0000",
                            {rsp0_valid, rsp1_valid, req0_ready, req1_ready}, rsp0_rdata);
      end
      PRDATA = 32'hCAFE_0010;
      step();
      req1_valid = 1'b0;
      n_checks++;
      if (PADDR !== 32'h10 || PWRITE !== 1'b0) begin
         n_fail++; $display("FAIL rr_setup1: got addr=%h write=%b want 10/0", PADDR, PWRITE);
      end
      step();
      step();
      n_checks++;
      if ({rsp0_valid, rsp1_valid, rsp1_err} !== 3'b010 || rsp1_rdata !== 32'hCAFE_0010) begin
         n_fail++; $display("FAIL rr_rsp1: got v0/v1/err=%b rdata=%h want 010 cafe0010",
                            {rsp0_valid, rsp1_valid, rsp1_err}, rsp1_rdata);
      end
   endtask

   task automatic test_single_write();
      step();
      req0_valid = 1'b1; req0_addr = 32'h04; req0_write = 1'b1; req0_wdata = 32'hA5A5_0001;
      PREADY = 1'b1; PRDATA = 32'h7777_7777;
      #1;
      n_checks++;
      if ({req0_ready, req1_ready, PSEL} !== 3'b100) begin
         n_fail++; $display("FAIL wr_accept: got r0/r1/sel=%b want 100", {req0_ready, req1_ready, PSEL});
      end
      step();
      req0_valid = 1'b0;
      n_checks++;
      if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PADDR !== 32'h04 || PWDATA !== 32'hA5A5_0001) begin
         n_fail++; $display("FAIL wr_setup: got sel/en/wr=%b addr=%h wdata=%h want 101 04 a5a50001",
                            {PSEL, PENABLE, PWRITE}, PADDR, PWDATA);
      end
      step();
      n_checks++;
      if ({PSEL, PENABLE, rsp0_valid} !== 3'b110) begin
         n_fail++; $display("FAIL wr_access: got sel/en/v0=%b want 110", {PSEL, PENABLE, rsp0_valid});
      end
      step();
      n_checks++;
      if ({rsp0_valid, rsp0_err, rsp1_valid, PSEL} !== 4'b1000 || rsp0_rdata !== 32'h0) begin
         n_fail++; $display("FAIL wr_rsp: got v0/err/v1/sel=%b rdata=%h want 1000 0",
                            {rsp0_valid, rsp0_err, rsp1_valid, PSEL}, rsp0_rdata);
      end
      step();
      n_checks++;
      if (rsp0_valid !== 1'b0) begin
         n_fail++; $display("FAIL wr_rsp_pulse: got v0=%b want 0", rsp0_valid);
      end
   endtask

   task automatic test_round_robin_repeat();
      step();
      req0_valid = 1'b1; req0_addr = 32'h00; req0_write = 1'b0;
      req1_valid = 1'b1; req1_addr = 32'h10; req1_write = 1'b0;
      PREADY = 1'b1; PRDATA = 32'h0000_00B1;
      #1;
      n_checks++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         n_fail++; $display("FAIL rr_repeat_grant: got r0/r1=%b want 01", {req0_ready, req1_ready});
      end
      step();
      req1_valid = 1'b0;
      step();
      step();
      n_checks++;
      if ({rsp1_valid, rsp0_valid, req0_ready} !== 3'b101 || rsp1_rdata !== 32'h0000_00B1) begin
         n_fail++; $display("FAIL rr_repeat_rsp1: got v1/v0/r0=%b rdata=%h want 101 b1",
                            {rsp1_valid, rsp0_valid, req0_ready}, rsp1_rdata);
      end
      step();
      req0_valid = 1'b0;
      step();
      step();
      n_checks++;
      if ({rsp0_valid, rsp1_valid} !== 2'b10) begin
         n_fail++; $display("FAIL rr_repeat_rsp0: got v0/v1=%b want 10", {rsp0_valid, rsp1_valid});
      end
   endtask

   task automatic test_wait_states();
      step();
      req1_valid = 1'b1; req1_addr = 32'h14; req1_write = 1'b0;
      PREADY = 1'b0; PRDATA = 32'h0;
      #1;
      n_checks++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         n_fail++; $display("FAIL ws_accept: got r0/r1=%b want 01", {req0_ready, req1_ready});
      end
      step();
      req1_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if ({PSEL, PENABLE, rsp1_valid} !== 3'b110 || PADDR !== 32'h14) begin
            n_fail++; $display("FAIL ws_hold%0d: got sel/en/v1=%b addr=%h want 110 14",
                               i, {PSEL, PENABLE, rsp1_valid}, PADDR);
         end
      end
      step();
      n_checks++;
      if ({PSEL, PENABLE, rsp1_valid} !== 3'b110 || PADDR !== 32'h14) begin
         n_fail++; $display("FAIL ws_last: got sel/en/v1=%b addr=%h want 110 14",
                            {PSEL, PENABLE, rsp1_valid}, PADDR);
      end
      PREADY = 1'b1; PRDATA = 32'hDEAD_BEEF;
      step();
      n_checks++;
      if ({rsp1_valid, rsp1_err, rsp0_valid} !== 3'b100 || rsp1_rdata !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL ws_rsp: got v1/err/v0=%b rdata=%h want 100 deadbeef",
                            {rsp1_valid, rsp1_err, rsp0_valid}, rsp1_rdata);
      end
   endtask

   task automatic test_timeout();
      step();
      req0_valid = 1'b1; req0_addr = 32'h20; req0_write = 1'b0;
      PREADY = 1'b0; PRDATA = 32'h1234_5678;
      #1;
      n_checks++;
      if (req0_ready !== 1'b1) begin
         n_fail++; $display("FAIL to_accept: got r0=%b want 1", req0_ready);
      end
      step();
      req0_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if ({PENABLE, rsp0_valid} !== 2'b10) begin
            n_fail++; $display("FAIL to_wait%0d: got en/v0=%b want 10", i, {PENABLE, rsp0_valid});
         end
      end
      step();
      n_checks++;
      if ({rsp0_valid, rsp0_err, rsp1_valid, PSEL, PENABLE} !== 5'b11000 || rsp0_rdata !== 32'h0) begin
         n_fail++; $display("FAIL to_err: got v0/err/v1/sel/en=%b rdata=%h want 11000 0",
                            {rsp0_valid, rsp0_err, rsp1_valid, PSEL, PENABLE}, rsp0_rdata);
      end
      PREADY = 1'b1;
      step();
      n_checks++;
      if ({rsp0_valid, rsp0_err} !== 2'b00) begin
         n_fail++; $display("FAIL to_clear: got v0/err=%b want 00", {rsp0_valid, rsp0_err});
      end
   endtask

   task automatic test_reset_mid_access();
      step();
      req1_valid = 1'b1; req1_addr = 32'h30; req1_write = 1'b1; req1_wdata = 32'h5555;
      PREADY = 1'b0;
      step();
      req1_valid = 1'b0;
      step();
      n_checks++;
      if ({PSEL, PENABLE} !== 2'b11) begin
         n_fail++; $display("FAIL rst_mid_access: got sel/en=%b want 11", {PSEL, PENABLE});
      end
      #2 PRESETn = 1'b0;
      #1;
      n_checks++;
      if ({PSEL, PENABLE} !== 2'b00 || PADDR !== 32'h0) begin
         n_fail++; $display("FAIL rst_mid_async: got sel/en=%b addr=%h want 00 0", {PSEL, PENABLE}, PADDR);
      end
      step();
      n_checks++;
      if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
         n_fail++; $display("FAIL rst_mid_norsp: got v0/v1=%b want 00", {rsp0_valid, rsp1_valid});
      end
      step();
      PRESETn = 1'b1;
      req0_valid = 1'b1; req0_addr = 32'h34; req0_write = 1'b1; req0_wdata = 32'h66;
      PREADY = 1'b1;
      #1;
      n_checks++;
      if (req0_ready !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid_reaccept: got r0=%b want 1", req0_ready);
      end
      step();
      req0_valid = 1'b0;
      step();
      step();
      n_checks++;
      if ({rsp0_valid, rsp0_err, rsp1_valid} !== 3'b100) begin
         n_fail++; $display("FAIL rst_mid_next: got v0/err/v1=%b want 100", {rsp0_valid, rsp0_err, rsp1_valid});
      end
   endtask

   task automatic test_back_to_back();
      int g0 = 0;
      int g1 = 0;
      int cycles = 0;
      logic exp_next = 1'b1;
      step();
      req0_valid = 1'b1; req0_addr = 32'h50; req0_write = 1'b0;
      req1_valid = 1'b1; req1_addr = 32'h54; req1_write = 1'b0;
      PREADY = 1'b1; PRDATA = 32'h0;
      while ((g0 + g1) < 100 && cycles < 1000) begin
         #1;
         cycles++;
         n_checks++;
         if (req0_ready && req1_ready) begin
            n_fail++; $display("FAIL b2b_both_ready: cycle %0d got r0/r1=11 want not both", cycles);
         end
         if (req0_ready || req1_ready) begin
            n_checks++;
            if (req1_ready !== exp_next) begin
               n_fail++; $display("FAIL b2b_alternate: grant %0d got r1=%b want %b", g0 + g1, req1_ready, exp_next);
            end
            if (req0_ready) g0++;
            else            g1++;
            exp_next = ~exp_next;
         end
         @(negedge PCLK);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      n_checks++;
      if (g0 !== 50 || g1 !== 50) begin
         n_fail++; $display("FAIL b2b_counts: got %0d/%0d after %0d cycles want 50/50", g0, g1, cycles);
      end
      repeat (4) step();
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single_write();
      test_round_robin_repeat();
      test_wait_states();
      test_timeout();
      test_reset_mid_access();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before end of test");
      $fatal(1);
   end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: APB address width.
REQ-002 Parameter DATA_W, default 32: APB data width.
REQ-003 Parameter TIMEOUT, default 16: ACCESS-phase cycles waited for PREADY before an error completion; legal range 2..255.
REQ-004 PCLK  input  1  APB clock; one clock; all state on rising edge.
REQ-005 PRESETn  input  1  asynchronous active-low reset.
REQ-006 reqN_valid  input  1  requester N (N=0,1) has a transfer pending; held until accepted.
REQ-007 reqN_ready  output  1  requester N transfer accepted this cycle.
REQ-008 reqN_addr  input  ADDR_W  requester N target address.
REQ-009 reqN_write  input  1  requester N: 1=write, 0=read.
REQ-010 reqN_wdata  input  DATA_W  requester N write data.
REQ-011 rspN_valid  output  1  one-cycle completion pulse to requester N.
REQ-012 rspN_rdata  output  DATA_W  read data; 0 for writes and for errors.
REQ-013 rspN_err  output  1  completion was a timeout.
REQ-014 PADDR, PWRITE, PWDATA  output  ADDR_W/1/DATA_W  APB master address, direction, write data.
REQ-015 PSEL, PENABLE  output  1/1  APB master select and enable.
REQ-016 PRDATA, PREADY  input  DATA_W/1  APB read data and ready from the decoded slave mux.

Function
REQ-017 FSM states: IDLE, SETUP, ACCESS.
REQ-018 IDLE: if any reqN_valid, the arbiter SHALL pick one winner, assert that reqN_ready for exactly that cycle, register its addr/write/wdata onto PADDR/PWRITE/PWDATA, and go to SETUP.
REQ-019 Arbitration SHALL be round-robin: when both are valid, the requester not granted last wins; after reset requester 0 has priority.
REQ-020 SETUP: PSEL=1, PENABLE=0 for exactly one cycle; next state ACCESS.
REQ-021 ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA SHALL be held stable; a wait counter SHALL start at 0 and increment once per cycle in which PREADY=0.
REQ-022 ACCESS with PREADY=1: normal completion; next cycle rspN_valid=1 to the owner, rspN_rdata=PRDATA sampled for reads (0 for writes), rspN_err=0; state returns to IDLE.
REQ-023 ACCESS with PREADY=0 and the wait counter at TIMEOUT-1: error completion; rspN_valid=1, rspN_err=1, rspN_rdata=0; state returns to IDLE.
REQ-024 PREADY=1 in the timeout cycle SHALL take precedence (normal completion).
REQ-025 Minimum transfer SHALL be 3 cycles, accept to completion; no new request SHALL be accepted in SETUP or ACCESS; back-to-back transfers SHALL see PSEL drop to 0 for the IDLE accept cycle.
REQ-026 reqN_ready SHALL never be asserted for both requesters in the same cycle, and only in IDLE.
REQ-027 Only the transfer owner's rspN_valid SHALL pulse; the other rsp outputs SHALL stay 0.
REQ-028 A requester that drops reqN_valid before acceptance SHALL not be granted.

Reset
REQ-029 On PRESETn=0 the block SHALL go to IDLE immediately and drive PSEL, PENABLE, PWRITE, reqN_ready, rspN_valid, rspN_err = 0 and PADDR, PWDATA, rspN_rdata = 0. Round-robin pointer resets to favour requester 0; wait counter resets to 0.
REQ-030 Reset mid-transfer SHALL abort the transfer with no response pulse; after release, requests SHALL be accepted from IDLE on the first rising edge.

Structure
REQ-031 Package apb_arb_pkg SHALL hold the FSM state enum (IDLE/SETUP/ACCESS) and the default TIMEOUT constant.
REQ-032 Sub-module rr_arb2 (2-way round-robin grant with a last-grant register) SHALL be instantiated once; everything else stays in apb_req_arbiter.

Verification
REQ-033 req0 write addr=0x04 wdata=0xA5A5_0001, PREADY=1 -> PSEL rises 1 cycle after ack, PENABLE 1 cycle later, rsp0_valid on cycle 3, err=0.
REQ-034 req0 and req1 valid together, reads of 0x00 and 0x10, PREADY=1 -> req0 served first, then req1; a repeat of both -> req1 first.
REQ-035 req1 read addr=0x14, PREADY held 0 for 3 ACCESS cycles then 1 with PRDATA=0xDEAD_BEEF -> rsp1_rdata=0xDEAD_BEEF, err=0, PADDR stable throughout.
REQ-036 TIMEOUT=4, PREADY stuck 0 -> rsp0_valid with err=1 and rdata=0 after 4 ACCESS cycles, FSM back in IDLE.
REQ-037 PRESETn asserted during ACCESS -> PSEL/PENABLE drop to 0 asynchronously, no rsp pulse; next request completes normally.
REQ-038 Continuous requests on both ports for 100 transfers -> strict alternation, never both readies high, grant counts 50/50.
